alu_serial_seq: RTL and testbench

Bit-serial ALU sequencer: computes one W-bit ALU operation by stepping a single 1-bit ALU slice (AND/OR/ADD, A/B invert, carry chain, less/set) over W cycles, LSB first. It holds the operands, carry and partial result, and handles the SLT fix-up and the flag generation. It sits beside the combinational ALU as a low-area option for the multi-cycle datapath and uses a start/done handshake.

---
 rtl/alu_serial_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_serial_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU sequencer stepping a 1-bit slice over W cycles
module alu_serial_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   alu_ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         overflow
);

  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [3:0]     ctrl_q, ctrl_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic           set_q, set_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d;
  logic           overflow_q, overflow_d;
  logic           done_q, done_d;

  // one-bit ALU slice signals for the bit currently selected by the counter
  logic           ai, bi, sum, cout, rbit;
  logic [W-1:0]   fin_res;

  // state, operand, slice and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sreg_q     <= '0;
      set_q      <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      set_q      <= set_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // the 1-bit slice: optional inversion, full adder and op mux (less input is 0)
  always_comb begin
    ai   = a_q[cnt_q] ^ ctrl_q[3];
    bi   = b_q[cnt_q] ^ ctrl_q[2];
    sum  = ai ^ bi ^ carry_q;
    cout = (ai & bi) | (ai & carry_q) | (bi & carry_q);
    case (ctrl_q[1:0])
      2'b00:   rbit = ai & bi;
      2'b01:   rbit = ai | bi;
      2'b10:   rbit = sum;
      default: rbit = 1'b0;
    endcase
  end

  // final result selection: SLT fix-up uses the MSB sum corrected by overflow
  always_comb begin
    fin_res = '0;
    case (ctrl_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: fin_res = sreg_q;
      OP_SLT:  fin_res = {{(W-1){1'b0}}, set_q ^ ovf_q};
      default: fin_res = '0;
    endcase
  end

  // next-state and datapath sequencing for IDLE -> RUN -> FIN -> IDLE
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    set_d      = set_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ctrl_d  = alu_ctrl;
          carry_d = alu_ctrl[2];
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // LSB enters first and is shifted down to bit 0 after W steps
        sreg_d  = {rbit, sreg_q[W-1:1]};
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          set_d   = sum;
          ovf_d   = carry_q ^ cout;
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        result_d   = fin_res;
        zero_d     = (fin_res == '0);
        overflow_d = ((ctrl_q == OP_ADD) || (ctrl_q == OP_SUB)) ? ovf_q : 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed table-driven bench for alu_serial_seq
module tb_alu_serial_seq;

  localparam int W = 32;
  localparam int NV = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [3:0]   ctrl;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [NV];

  alu_serial_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the start-sampling edge
  task automatic start_op(input logic [3:0] ctrl, input logic [W-1:0] va, input logic [W-1:0] vb);
    alu_ctrl = ctrl;
    a        = va;
    b        = vb;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_ctrl = 4'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // counts edges until done, optionally pulsing start with junk at step poke
  task automatic wait_done(input int poke, input logic [W-1:0] prev, output int lat, output logic held);
    lat  = 0;
    held = 1'b1;
    while (!done && lat < 40) begin
      if (result !== prev) held = 1'b0;
      if (lat == poke) begin
        start    = 1'b1;
        a        = '0;
        b        = '0;
        alu_ctrl = 4'b0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_done(input string name, input int lat, input logic held,
                            input logic [W-1:0] er, input logic ez, input logic eo);
    chk({name, "_latency"}, 32'(lat), 32'(W + 1));
    chk({name, "_held"}, {31'd0, held}, 32'd1);
    chk({name, "_result"}, result, er);
    chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
    chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int           lat;
    logic         held;
    logic         saw_done;
    logic [W-1:0] prev;

    vecs[0]  = '{"add_pos_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{"add_wrap",    4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{"sub_eq",      4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[3]  = '{"sub_neg_ovf", 4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4]  = '{"slt_neg",     4'b0111, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 1'b0, 1'b0};
    vecs[5]  = '{"slt_ovfcorr", 4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vecs[6]  = '{"slt_minpos",  4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
    vecs[7]  = '{"slt_gt",      4'b0111, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{"and",         4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[9]  = '{"or",          4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[10] = '{"nor_zero",    4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{"nor",         4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0};
    vecs[12] = '{"unsupported", 4'b0101, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{"sub_neg",     4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[14] = '{"and_ovf_lo",  4'b0000, 32'hFFFFFFFF, 32'h80000001, 32'h80000001, 1'b0, 1'b0};
    vecs[15] = '{"add_small",   4'b0010, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    alu_ctrl = '0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      prev = result;
      start_op(vecs[i].ctrl, vecs[i].va, vecs[i].vb);
      wait_done(-1, prev, lat, held);
      check_done(vecs[i].name, lat, held, vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_ovf);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
    end

    // reset in the middle of RUN abandons the operation
    start_op(4'b0010, 32'h00000010, 32'h00000020);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
    prev = result;
    start_op(4'b0010, 32'h00000010, 32'h00000020);
    wait_done(-1, prev, lat, held);
    check_done("post_rst_add", lat, held, 32'h00000030, 1'b0, 1'b0);
    @(negedge clk);

    // start re-asserted at RUN bit 5 with other operands is ignored
    prev = result;
    start_op(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    wait_done(5, prev, lat, held);
    check_done("busy_start", lat, held, 32'h80000000, 1'b0, 1'b1);

    // start in the done cycle is accepted; outputs hold until the new FIN
    prev = result;
    start_op(4'b0110, 32'h00000005, 32'h00000005);
    chk("chain_done_falls", {31'd0, done}, 32'd0);
    chk("chain_result_held", result, 32'h80000000);
    chk("chain_ovf_held", {31'd0, overflow}, 32'd1);
    wait_done(-1, prev, lat, held);
    check_done("chain_sub", lat, held, 32'h00000000, 1'b1, 1'b0);
    @(negedge clk);
    chk("chain_done_pulse", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
